// File: rtl/pwm_motor_sequencer_pkg.sv
// Shared types and helpers for the motor PWM sequencer: state encoding,
// tick divider, ceiling log2 and the per-tick slew clamp.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } seq_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    function automatic int tick_div(input int sys_clk, input int tick_hz);
        return sys_clk / tick_hz;
    endfunction

    function automatic logic signed [31:0] slew_clamp(input logic signed [31:0] diff,
                                                      input logic signed [31:0] step);
        logic signed [31:0] res;
        if (diff > step) begin
            res = step;
        end else if (diff < -step) begin
            res = -step;
        end else begin
            res = diff;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_motor_sequencer_if.sv
// Duty command channel between the register file (master) and the sequencer (slave).
interface pwm_motor_sequencer_if #(
    parameter int MOTORS = 4,
    parameter int DUTY_W = 9
);
    import pwm_seq_pkg::*;

    localparam int IDX_W = (clog2(MOTORS) > 32'sd0) ? clog2(MOTORS) : 32'sd1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [IDX_W-1:0]  cmd_idx;
    logic [DUTY_W-1:0] cmd_duty;

    modport master (output cmd_valid, output cmd_idx, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_idx, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/pwm_motor_sequencer_slew.sv
// Per-motor target/duty holder: moves duty toward target by a bounded step on each tick.
module motor_slew
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W    = 9,
    parameter int IDLE_DUTY = 26,
    parameter int SLEW_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              slew_en,
    input  logic              load,
    input  logic [DUTY_W-1:0] load_duty,
    input  logic              force_idle,
    input  logic              force_zero,
    input  logic              fail,
    output logic [DUTY_W-1:0] duty
);

    localparam logic [DUTY_W-1:0] IDLE = DUTY_W'(IDLE_DUTY);

    logic [DUTY_W-1:0]        target_r;
    logic [DUTY_W-1:0]        duty_r;
    logic [DUTY_W-1:0]        eff_target_s;
    logic [DUTY_W-1:0]        next_duty_s;
    logic signed [DUTY_W+1:0] diff_s;
    logic signed [DUTY_W+1:0] delta_s;
    logic signed [DUTY_W+1:0] sum_s;

    // Target in force this cycle; a command landing on a tick cycle is used by that tick.
    always_comb begin
        if (fail) begin
            eff_target_s = IDLE;
        end else if (load) begin
            eff_target_s = (load_duty > IDLE) ? load_duty : IDLE;
        end else begin
            eff_target_s = target_r;
        end
    end

    // One clamped step toward the target, saturated to the unsigned duty range.
    always_comb begin
        diff_s  = $signed({2'b00, eff_target_s}) - $signed({2'b00, duty_r});
        delta_s = (DUTY_W+2)'(slew_clamp(32'(diff_s), 32'(SLEW_STEP)));
        sum_s   = $signed({2'b00, duty_r}) + delta_s;
        if (sum_s[DUTY_W+1]) begin
            next_duty_s = '0;
        end else if (sum_s[DUTY_W]) begin
            next_duty_s = '1;
        end else begin
            next_duty_s = sum_s[DUTY_W-1:0];
        end
    end

    // Target and duty registers with forced zero/idle overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_r <= '0;
            duty_r   <= '0;
        end else if (force_zero) begin
            target_r <= '0;
            duty_r   <= '0;
        end else if (force_idle) begin
            target_r <= IDLE;
            duty_r   <= IDLE;
        end else begin
            target_r <= eff_target_s;
            if (tick && slew_en) begin
                duty_r <= next_duty_s;
            end
        end
    end

    assign duty = duty_r;

endmodule

// File: rtl/pwm_motor_sequencer.sv
// ESC arm/disarm sequencer with tick prescaler, duty slew and watchdog failsafe.
// Define PWM_SEQ_STAGGER_EN to bring motors up to idle one after another while arming.
module pwm_motor_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int MOTORS     = 4,
    parameter int DUTY_W     = 9,
    parameter int SYS_CLK    = 100000000,
    parameter int TICK_HZ    = 1000,
    parameter int IDLE_DUTY  = 26,
    parameter int SLEW_STEP  = 4,
    parameter int ARM_TICKS  = 2000,
    parameter int WDOG_TICKS = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_req,
    input  logic                     disarm_req,
    pwm_motor_sequencer_if.slave     cmd,
    output logic [MOTORS*DUTY_W-1:0] duty_out,
    output logic                     pwm_ena,
    output logic [1:0]               state,
    output logic                     fault
);

    localparam int TDIV  = tick_div(SYS_CLK, TICK_HZ);
    localparam int PRE_W = clog2(TDIV) + 32'sd1;
    localparam int ARM_W = clog2(ARM_TICKS) + 32'sd1;
    localparam int WD_W  = clog2(WDOG_TICKS) + 32'sd1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TDIV - 32'sd1);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_TICKS - 32'sd1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WDOG_TICKS - 32'sd1);
    localparam logic [DUTY_W-1:0] IDLE     = DUTY_W'(IDLE_DUTY);
`ifdef PWM_SEQ_STAGGER_EN
    localparam int STAG_STEP = ARM_TICKS / MOTORS;
`endif

    seq_state_e        state_r;
    logic [PRE_W-1:0]  pre_r;
    logic [ARM_W-1:0]  arm_cnt_r;
    logic [ARM_W-1:0]  arm_next_s;
    logic [WD_W-1:0]   wdog_r;
    logic              cmd_ready_r;
    logic              tick_s;
    logic              accept_s;
    logic              arm_go_s;
    logic              disarm_go_s;
    logic              slew_en_s;
    logic              fail_s;
    logic              all_idle_s;
    logic [MOTORS-1:0] load_s;
    logic [MOTORS-1:0] force_idle_s;
    logic [MOTORS-1:0] idle_s;
    logic [DUTY_W-1:0] duty_s [MOTORS];

    assign tick_s      = (pre_r == PRE_LAST);
    assign accept_s    = cmd.cmd_valid && cmd_ready_r;
    assign arm_go_s    = (state_r == ST_DISARMED) && arm_req && !disarm_req;
    assign arm_next_s  = arm_cnt_r + ARM_W'(1);
    assign slew_en_s   = (state_r == ST_ARMED) || (state_r == ST_FAILSAFE);
    assign fail_s      = (state_r == ST_FAILSAFE);
    assign all_idle_s  = &idle_s;

    // Control tick prescaler, free running from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Disarm is unconditional while arming/armed, but failsafe only releases once every motor sits at idle.
    always_comb begin
        case (state_r)
            ST_ARMING, ST_ARMED: disarm_go_s = disarm_req;
            ST_FAILSAFE:         disarm_go_s = disarm_req && all_idle_s;
            default:             disarm_go_s = 1'b0;
        endcase
    end

    // Per-motor command steering and idle forcing on arm entry / stagger points.
    always_comb begin
        load_s       = '0;
        force_idle_s = '0;
        for (int k = 0; k < MOTORS; k++) begin
            load_s[k] = accept_s && (32'(cmd.cmd_idx) == 32'(k));
`ifdef PWM_SEQ_STAGGER_EN
            if (arm_go_s && ((k * STAG_STEP) == 32'sd0)) begin
                force_idle_s[k] = 1'b1;
            end else if ((state_r == ST_ARMING) && tick_s && !disarm_req &&
                         (32'(arm_next_s) >= 32'(k * STAG_STEP))) begin
                force_idle_s[k] = 1'b1;
            end else begin
                force_idle_s[k] = 1'b0;
            end
`else
            force_idle_s[k] = arm_go_s;
`endif
        end
    end

    // Arm/disarm/failsafe state machine with arm and watchdog counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_DISARMED;
            arm_cnt_r   <= '0;
            wdog_r      <= '0;
            pwm_ena     <= 1'b0;
            cmd_ready_r <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state_r)
                ST_DISARMED: begin
                    if (arm_go_s) begin
                        state_r   <= ST_ARMING;
                        arm_cnt_r <= '0;
                        pwm_ena   <= 1'b1;
                    end
                end
                ST_ARMING: begin
                    if (disarm_go_s) begin
                        state_r <= ST_DISARMED;
                        pwm_ena <= 1'b0;
                    end else if (tick_s) begin
                        if (arm_cnt_r == ARM_LAST) begin
                            state_r     <= ST_ARMED;
                            wdog_r      <= '0;
                            cmd_ready_r <= 1'b1;
                        end else begin
                            arm_cnt_r <= arm_next_s;
                        end
                    end
                end
                ST_ARMED: begin
                    if (disarm_go_s) begin
                        state_r     <= ST_DISARMED;
                        pwm_ena     <= 1'b0;
                        cmd_ready_r <= 1'b0;
                    end else if (accept_s) begin
                        wdog_r <= '0;
                    end else if (tick_s) begin
                        if (wdog_r == WD_LAST) begin
                            state_r     <= ST_FAILSAFE;
                            fault       <= 1'b1;
                            cmd_ready_r <= 1'b0;
                        end else begin
                            wdog_r <= wdog_r + WD_W'(1);
                        end
                    end
                end
                ST_FAILSAFE: begin
                    if (disarm_go_s) begin
                        state_r <= ST_DISARMED;
                        pwm_ena <= 1'b0;
                        fault   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_DISARMED;
                    pwm_ena     <= 1'b0;
                    cmd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < MOTORS; k++) begin : g_motor
        motor_slew #(
            .DUTY_W    (DUTY_W),
            .IDLE_DUTY (IDLE_DUTY),
            .SLEW_STEP (SLEW_STEP)
        ) u_slew (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick_s),
            .slew_en    (slew_en_s),
            .load       (load_s[k]),
            .load_duty  (cmd.cmd_duty),
            .force_idle (force_idle_s[k]),
            .force_zero (disarm_go_s),
            .fail       (fail_s),
            .duty       (duty_s[k])
        );
        assign duty_out[k*DUTY_W +: DUTY_W] = duty_s[k];
        assign idle_s[k] = (duty_s[k] == IDLE);
    end

    assign cmd.cmd_ready = cmd_ready_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pwm_motor_sequencer.sv
// Self-checking bench for pwm_motor_sequencer: behavioural model plus directed literal checks.
module tb_pwm_motor_sequencer;

    localparam int MOTORS = 4;
    localparam int DUTY_W = 9;
    localparam int IDLE   = 26;
    localparam int STEP   = 4;
    localparam int WD     = 3;
    localparam int DIV    = 10;
`ifdef PWM_SEQ_STAGGER_EN
    localparam int ARM     = 8;
    localparam bit STAGGER = 1'b1;
`else
    localparam int ARM     = 5;
    localparam bit STAGGER = 1'b0;
`endif
    localparam int STG = ARM / MOTORS;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     arm_req;
    logic                     disarm_req;
    logic [MOTORS*DUTY_W-1:0] duty_out;
    logic                     pwm_ena;
    logic [1:0]               state;
    logic                     fault;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_motor_sequencer_if #(.MOTORS(MOTORS), .DUTY_W(DUTY_W)) cmd_bus ();

    pwm_motor_sequencer #(
        .MOTORS(MOTORS), .DUTY_W(DUTY_W), .SYS_CLK(1000), .TICK_HZ(100),
        .IDLE_DUTY(IDLE), .SLEW_STEP(STEP), .ARM_TICKS(ARM), .WDOG_TICKS(WD)
    ) dut (
        .clk(clk), .rst(rst), .arm_req(arm_req), .disarm_req(disarm_req),
        .cmd(cmd_bus.slave), .duty_out(duty_out), .pwm_ena(pwm_ena),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_state = 0, m_pre = 0, m_arm = 0, m_wd = 0;
    int m_ena = 0, m_rdy = 0, m_fault = 0;
    int m_duty [MOTORS] = '{default: 0};
    int m_tgt  [MOTORS] = '{default: 0};

    task automatic m_disarm();
        m_state = 0; m_ena = 0; m_rdy = 0;
        for (int k = 0; k < MOTORS; k++) begin m_duty[k] = 0; m_tgt[k] = 0; end
    endtask

    task automatic m_slew();
        int d;
        for (int k = 0; k < MOTORS; k++) begin
            d = m_tgt[k] - m_duty[k];
            if (d > STEP) d = STEP;
            if (d < -STEP) d = -STEP;
            m_duty[k] = m_duty[k] + d;
            if (m_duty[k] < 0) m_duty[k] = 0;
            if (m_duty[k] > (1 << DUTY_W) - 1) m_duty[k] = (1 << DUTY_W) - 1;
        end
    endtask

    function automatic bit m_all_idle();
        bit r = 1'b1;
        for (int k = 0; k < MOTORS; k++) if (m_duty[k] != IDLE) r = 1'b0;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit tk, acc;
        if (rst) begin
            m_pre = 0; m_arm = 0; m_wd = 0; m_fault = 0;
            m_disarm();
        end else begin
            tk    = (m_pre == DIV - 1);
            m_pre = tk ? 0 : m_pre + 1;
            acc   = cmd_bus.cmd_valid && (m_rdy != 0);
            if (acc && int'(cmd_bus.cmd_idx) < MOTORS)
                m_tgt[cmd_bus.cmd_idx] = (int'(cmd_bus.cmd_duty) > IDLE) ? int'(cmd_bus.cmd_duty) : IDLE;
            case (m_state)
                0: if (arm_req && !disarm_req) begin
                    m_state = 1; m_ena = 1; m_arm = 0;
                    for (int k = 0; k < MOTORS; k++) begin
                        m_duty[k] = (!STAGGER || k * STG == 0) ? IDLE : 0;
                        m_tgt[k]  = m_duty[k];
                    end
                end
                1: if (disarm_req) m_disarm();
                   else if (tk) begin
                       for (int k = 0; k < MOTORS; k++)
                           if (STAGGER && m_arm + 1 >= k * STG) begin m_duty[k] = IDLE; m_tgt[k] = IDLE; end
                       if (m_arm == ARM - 1) begin m_state = 2; m_wd = 0; m_rdy = 1; end
                       else m_arm = m_arm + 1;
                   end
                2: if (disarm_req) m_disarm();
                   else begin
                       if (tk) m_slew();
                       if (acc) m_wd = 0;
                       else if (tk) begin
                           if (m_wd == WD - 1) begin m_state = 3; m_fault = 1; m_rdy = 0; end
                           else m_wd = m_wd + 1;
                       end
                   end
                default: begin
                    for (int k = 0; k < MOTORS; k++) m_tgt[k] = IDLE;
                    if (disarm_req && m_all_idle()) begin m_disarm(); m_fault = 0; end
                    else if (tk) m_slew();
                end
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_duty(input int k);
        return int'(duty_out[k*DUTY_W +: DUTY_W]);
    endfunction

    always @(negedge clk) begin : compare
        check("state", int'(state), m_state);
        check("pwm_ena", int'(pwm_ena), m_ena);
        check("fault", int'(fault), m_fault);
        check("cmd_ready", int'(cmd_bus.cmd_ready), m_rdy);
        for (int k = 0; k < MOTORS; k++) check($sformatf("duty%0d", k), dut_duty(k), m_duty[k]);
    end

    // ---------------- stimulus ----------------
    task automatic sync_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (m_pre != 0 && n < 2 * DIV);
        check("tick_sync", m_pre, 0);
    endtask

    task automatic send(input int idx, input int duty);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_idx   = idx[1:0];
        cmd_bus.cmd_duty  = DUTY_W'(duty);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse(input bit a, input bit d);
        arm_req = a; disarm_req = d;
        @(negedge clk);
        arm_req = 1'b0; disarm_req = 1'b0;
    endtask

    int slew2 [4] = '{30, 34, 38, 40};

    initial begin
        rst = 1'b1; arm_req = 1'b0; disarm_req = 1'b0;
        cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_idx = '0; cmd_bus.cmd_duty = '0;
        #12;
        check("rst_state", int'(state), 0);
        check("rst_ena", int'(pwm_ena), 0);
        check("rst_ready", int'(cmd_bus.cmd_ready), 0);
        check("rst_duty", int'(duty_out == '0), 1);
        @(negedge clk);
        rst = 1'b0;

        // Arming sequence
        pulse(1'b1, 1'b0);
        check("arm_state", int'(state), 1);
        for (int k = 0; k < MOTORS; k++) check("arm_duty", dut_duty(k), (!STAGGER || k == 0) ? IDLE : 0);
        for (int i = 1; i <= ARM; i++) begin
            sync_tick();
            check("arming_state", int'(state), (i < ARM) ? 1 : 2);
            check("arming_ena", int'(pwm_ena), 1);
            for (int k = 0; k < MOTORS; k++)
                check("arming_duty", dut_duty(k), (!STAGGER || i >= k * STG) ? IDLE : 0);
        end

        // Slew on motor 2 toward 40, kept alive
        for (int i = 0; i < 4; i++) begin
            send(2, 40);
            sync_tick();
            check("slew_duty2", dut_duty(2), slew2[i]);
            check("slew_duty0", dut_duty(0), IDLE);
        end

        // Idle floor and last-command-wins
        send(0, 10);
        sync_tick();
        check("clamp_duty0", dut_duty(0), IDLE);
        send(1, 100);
        send(1, 50);
        sync_tick();
        check("lastwin_duty1", dut_duty(1), 30);
        for (int t = 2; t <= 7; t++) begin
            send(3, 26);
            sync_tick();
            check("lastwin_ramp1", dut_duty(1), (26 + 4 * t > 50) ? 50 : 26 + 4 * t);
        end

        // Watchdog failsafe and guarded disarm
        sync_tick();
        check("wdog_pre_state", int'(state), 2);
        sync_tick();
        check("wdog_state", int'(state), 3);
        check("wdog_fault", int'(fault), 1);
        check("wdog_ready", int'(cmd_bus.cmd_ready), 0);
        sync_tick();
        sync_tick();
        check("fs_ramp1", dut_duty(1), 42);
        pulse(1'b0, 1'b1);
        check("fs_disarm_ignored", int'(state), 3);
        check("fs_fault_held", int'(fault), 1);
        repeat (4) sync_tick();
        check("fs_idle1", dut_duty(1), IDLE);
        pulse(1'b0, 1'b1);
        check("fs_disarm_state", int'(state), 0);
        check("fs_disarm_fault", int'(fault), 0);
        check("fs_disarm_duty", int'(duty_out == '0), 1);

        // Simultaneous arm and disarm from DISARMED
        pulse(1'b1, 1'b1);
        check("prio_state", int'(state), 0);
        check("prio_ena", int'(pwm_ena), 0);

        // Re-arm, ramp, then asynchronous reset mid-ramp
        sync_tick();
        pulse(1'b1, 1'b0);
        repeat (ARM) sync_tick();
        check("rearm_state", int'(state), 2);
        pulse(1'b1, 1'b0);
        check("arm_ignored", int'(state), 2);
        send(0, 200);
        sync_tick();
        send(0, 200);
        sync_tick();
        check("ramp_duty0", dut_duty(0), 34);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_duty", int'(duty_out == '0), 1);
        check("async_rst_ena", int'(pwm_ena), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pwm_motor_sequencer.md
Name: pwm_motor_sequencer

Overview:
- Control-side sequencer for the multi-phase motor PWM generator.
- Owns the per-motor duty values and the PWM enable. Runs the ESC arm/disarm state machine and slew-limits duty changes on a fixed control tick.
- Forces a safe idle throttle when the CPU command stream stops (watchdog failsafe).
- Sits between the Wishbone register file (command side) and the PWM instances (duty/ena side).

Parameters:
- MOTORS, 4, number of motor channels.
- DUTY_W, 9, duty width; must match the PWM bit resolution.
- SYS_CLK, 100000000, clk frequency in Hz.
- TICK_HZ, 1000, control tick rate in Hz; TICK_DIV = SYS_CLK/TICK_HZ.
- IDLE_DUTY, 26, ESC idle/arming throttle code.
- SLEW_STEP, 4, maximum duty change per motor per tick.
- ARM_TICKS, 2000, ticks spent holding idle before ARMED.
- WDOG_TICKS, 100, ticks without an accepted command before FAILSAFE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- arm_req  in  1  single-cycle arm request.
- disarm_req  in  1  single-cycle disarm request.
- cmd_valid  in  1  duty command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_idx  in  clog2(MOTORS)  target motor index.
- cmd_duty  in  DUTY_W  requested duty.
- duty_out  out  MOTORS*DUTY_W  packed duties, motor 0 in the LSBs.
- pwm_ena  out  1  enable to the PWM duty-latch inputs.
- state  out  2  0=DISARMED, 1=ARMING, 2=ARMED, 3=FAILSAFE.
- fault  out  1  sticky watchdog fault.

Behaviour:
- Reset values: duty_out=0, pwm_ena=0, cmd_ready=0, state=DISARMED, fault=0. All targets, the tick prescaler and all counters are 0.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1, then wraps. Duty, arm and watchdog counters advance only on tick.
- cmd_ready=1 only in ARMED. On accept, target[cmd_idx] <= max(cmd_duty, IDLE_DUTY) and the watchdog counter clears.
- cmd_idx >= MOTORS: the command is accepted and discarded, and the watchdog still clears.
- Multiple commands to the same motor between ticks: the last one wins.
- Slew: on tick, per motor, duty += clamp(target-duty, -SLEW_STEP, +SLEW_STEP). Use signed DUTY_W+1 arithmetic with no wrap. The result saturates to [0, 2^DUTY_W-1].
- Latency: an accepted command first affects duty_out on the next tick edge, in the same cycle as tick.
- DISARMED:
  - duty_out=0, pwm_ena=0.
  - arm_req -> ARMING: all duty and target set to IDLE_DUTY, pwm_ena=1, arm counter=0.
- ARMING:
  - Duty is held at IDLE_DUTY; the arm counter increments on tick.
  - Counter reaching ARM_TICKS-1 on a tick -> ARMED; the watchdog counter clears.
  - disarm_req -> DISARMED.
- ARMED:
  - Slew toward targets; the watchdog increments on tick.
  - Watchdog reaching WDOG_TICKS-1 on a tick with no accept in that cycle -> FAILSAFE, fault=1.
  - disarm_req -> DISARMED immediately (duty 0).
- FAILSAFE:
  - All targets forced to IDLE_DUTY; slew continues downward and commands are refused.
  - disarm_req is honoured only when every duty==IDLE_DUTY. It then moves to DISARMED and clears fault. Otherwise it is ignored.
- Simultaneous arm_req and disarm_req: disarm wins. arm_req outside DISARMED is ignored.
- Simultaneous accept and watchdog expiry: the accept wins and there is no failsafe.
- Asynchronous reset mid-ramp drops to reset values immediately, with no ramp.

Optional Feature:
- Macro: PWM_SEQ_STAGGER_EN.
- Defined: in ARMING, motor k steps from 0 to IDLE_DUTY at arm tick k*(ARM_TICKS/MOTORS). Motors below k stay 0. This limits inrush; ARMED entry is unchanged.
- Undefined: all motors go to IDLE_DUTY together on entry to ARMING.

Decomposition:
- Package pwm_seq_pkg:
  - State encoding constants.
  - TICK_DIV computation.
  - clog2 function replacing the local log2 macro.
  - Slew clamp function.
- One natural sub-module: motor_slew, instantiated per motor via generate. It holds target and duty, takes tick, load and force_idle, and outputs duty.
- The FSM, prescaler and watchdog stay in the top module.

Test Plan:
All scenarios use SYS_CLK=1000, TICK_HZ=100 (tick every 10 clk), ARM_TICKS=5, WDOG_TICKS=3, IDLE_DUTY=26, SLEW_STEP=4.
- Arming: reset, then arm_req -> state=1 and all duty=26 the next cycle; state=2 after 5 ticks; pwm_ena=1 throughout.
- Slew: in ARMED, cmd idx=2 duty=40 -> duty2 goes 30, 34, 38, 40 on successive ticks; other motors stay at 26.
- Clamp and last-wins: cmd duty=10 -> target 26. Two commands to idx1 of 100 then 50 in one tick window -> duty1 ramps toward 50.
- Watchdog: no commands for 3 ticks -> state=3, fault=1, cmd_ready=0, duties ramp to 26. disarm_req before 26 is reached is ignored; after it -> state=0, fault=0, duty=0.
- Priority: arm_req and disarm_req in the same cycle from DISARMED -> stays state 0. Reset asserted mid-ramp -> duty_out=0 and state=0 with no clk edge.
- Stagger (PWM_SEQ_STAGGER_EN, MOTORS=4, ARM_TICKS=8): motor k reaches 26 at arm tick 2k.
